// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// pipe_ctrl_pkg
//------------------------------------------------------------------------------
// Shared types and constants for pipeline stall/flush control:
//   - sequencer state enum (3-bit, encoding is visible on the debug port)
//   - stage bit indices IF_B..WB_B for the 5-bit stall/flush vectors
//   - stall/flush patterns for each hazard class
//   - RV32 register-field slice helpers
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef LOAD
`include "define.sv"
`endif

package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    FLUSH    = 3'd2,
    MD_WAIT  = 3'd3,
    MEM_WAIT = 3'd4
  } state_e;

  // Stage bit positions inside the stall/flush vectors.
  localparam int IF_B  = 0;
  localparam int ID_B  = 1;
  localparam int EX_B  = 2;
  localparam int MEM_B = 3;
  localparam int WB_B  = 4;

  localparam logic [6:0] OPC_LOAD = `LOAD;

  // Freeze the whole pipe while data memory is busy.
  localparam logic [4:0] HOLD_ALL = 5'b11111;
  // Load-use: hold IF/ID, push a bubble into EX.
  localparam logic [4:0] LU_STALL = 5'b00011;
  localparam logic [4:0] LU_FLUSH = 5'b00100;
  // Mul/div busy: hold IF/ID/EX, bubble into MEM.
  localparam logic [4:0] MD_STALL = 5'b00111;
  localparam logic [4:0] MD_FLUSH = 5'b01000;
  // Taken branch: squash the two wrong-path instructions in ID and EX.
  localparam logic [4:0] BR_FLUSH = 5'b00110;
  // Extra flush cycles after the branch only need to clear ID.
  localparam logic [4:0] FL_FLUSH = 5'b00010;

  function automatic logic [4:0] rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

`default_nettype wire

// File: rtl/define.sv
//==============================================================================
// define.sv
//------------------------------------------------------------------------------
// Core-wide macros shared by the RV32 pipeline RTL.
//   `XLEN : architectural register / instruction width
//   `LOAD : RV32I major opcode of the load instructions (LB/LH/LW/LBU/LHU)
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`ifndef PIPE_DEFINE_SV
`define PIPE_DEFINE_SV

`define XLEN 32
`define LOAD 7'b0000011

`endif

// File: rtl/load_use_detect.sv
//==============================================================================
// load_use_detect
//------------------------------------------------------------------------------
// Flags a load in EX whose destination is read by the instruction in ID.
// Writes to x0 never create a dependency.
// Ports:
//   i_id_instr [XLEN-1:0] : instruction in ID (source registers)
//   i_ex_instr [XLEN-1:0] : instruction in EX (opcode and destination)
//   o_lu                  : load-use hazard present
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_id_instr,
  input  logic [XLEN-1:0] i_ex_instr,
  output logic            o_lu
);

  logic       w_is_load;
  logic [4:0] w_ex_rd;

  assign w_is_load = (i_ex_instr[6:0] == OPC_LOAD);
  assign w_ex_rd   = rd(i_ex_instr);

  assign o_lu = w_is_load && (w_ex_rd != 5'd0) &&
                ((w_ex_rd == rs1(i_id_instr)) || (w_ex_rd == rs2(i_id_instr)));

endmodule

`default_nettype wire

// File: rtl/pipe_sequencer.sv
//==============================================================================
// pipe_sequencer
//------------------------------------------------------------------------------
// Stall/flush sequencer for the 5-stage RV32 pipeline. Arbitrates load-use,
// taken branch, mul/div busy and data-memory wait hazards into per-stage
// hold (stall) and bubble (flush) controls, and counts stalled cycles.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   i_id_instr / i_ex_instr   : instructions in ID / EX
//   i_taken_branch            : EX resolved a taken branch/jump
//   i_md_busy                 : mul/div unit still working
//   i_dmem_req / i_dmem_ready : MEM outstanding access / completes now
//   o_stall [4:0]             : hold stage register, bit0 IF .. bit4 WB
//   o_flush [4:0]             : load bubble into stage, bit0 IF .. bit4 WB
//   o_state [2:0]             : current sequencer state (debug)
//   o_stall_cycles [CNT_W-1:0]: saturating count of cycles with any stall
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  i_id_instr,
  input  logic [XLEN-1:0]  i_ex_instr,
  input  logic             i_taken_branch,
  input  logic             i_md_busy,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic [4:0]       o_stall,
  output logic [4:0]       o_flush,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles
);

  // Counter preload: the entry cycle in RUN already produces the first
  // bubble, so the multi-cycle state covers the remaining N-1.
  localparam logic [1:0] LD_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

  state_e           r_state;
  state_e           r_ret;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  state_e     w_eff;
  state_e     w_nxt_state;
  state_e     w_nxt_ret;
  logic [1:0] w_nxt_cnt;
  logic [4:0] w_stall;
  logic [4:0] w_flush;
  logic       w_memw;
  logic       w_lu;
  logic       w_run;

  load_use_detect #(
    .XLEN (XLEN)
  ) u_lud (
    .i_id_instr (i_id_instr),
    .i_ex_instr (i_ex_instr),
    .o_lu       (w_lu)
  );

  assign w_memw = i_dmem_req & ~i_dmem_ready;

  // MEM_WAIT is transparent once memory is ready: the saved return state is
  // decoded in the same cycle, so a frozen LD_STALL/FLUSH count resumes.
  assign w_eff = (r_state == MEM_WAIT) ? r_ret : r_state;

  always_comb begin
    w_stall     = '0;
    w_flush     = '0;
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_nxt_cnt   = r_cnt;
    w_run       = 1'b0;

    if (w_memw) begin
      w_stall     = HOLD_ALL;
      w_nxt_state = MEM_WAIT;
      w_nxt_ret   = w_eff;
    end else begin
      w_nxt_state = w_eff;
      case (w_eff)
        LD_STALL: begin
          w_stall   = LU_STALL;
          w_flush   = LU_FLUSH;
          w_nxt_cnt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_nxt_state = RUN;
        end
        FLUSH: begin
          w_flush   = FL_FLUSH;
          w_nxt_cnt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_nxt_state = RUN;
        end
        MD_WAIT: begin
          if (i_md_busy) begin
            w_stall = MD_STALL;
            w_flush = MD_FLUSH;
          end else begin
            // Zero-cycle exit: the next hazard is resolved this same cycle.
            w_run = 1'b1;
          end
        end
        default: w_run = 1'b1;
      endcase

      if (w_run) begin
        w_nxt_state = RUN;
        if (i_taken_branch) begin
          w_flush = BR_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            w_nxt_state = FLUSH;
            w_nxt_cnt   = FL_INIT;
          end
        end else if (i_md_busy) begin
          w_stall     = MD_STALL;
          w_flush     = MD_FLUSH;
          w_nxt_state = MD_WAIT;
        end else if (w_lu) begin
          w_stall = LU_STALL;
          w_flush = LU_FLUSH;
          if (LOAD_STALL_CYCLES > 1) begin
            w_nxt_state = LD_STALL;
            w_nxt_cnt   = LD_INIT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_ret          <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ret   <= w_nxt_ret;
      r_cnt   <= w_nxt_cnt;
      if ((|w_stall) && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Controls are forced quiet while reset is held, independent of inputs.
  assign o_stall        = rst_n ? w_stall : 5'b00000;
  assign o_flush        = rst_n ? w_flush : 5'b00000;
  assign o_state        = r_state;
  assign o_stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
